// File: rtl/demux_pkg.sv
// Shared types and sizing for the registered 1:4 demultiplexer.
package demux_pkg;

    localparam int unsigned NCH   = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output channel register: loads on push, frees on pop, and a
// same-cycle push/pop keeps the channel full with the new word.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         pop,
    output logic [W-1:0] q,
    output logic         valid
);

    slot_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (load) state_nxt = FULL;
            FULL:  if (!load && pop) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Held word only changes on a load, so a stalled channel stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

    assign valid = (state == FULL);

endmodule

// File: rtl/demux1_4_seq.sv
// Registered 1:4 demultiplexer with per-channel valid/ready handshakes.
// Define DEMUX_RR_EN to replace in_sel with an internal round-robin pointer.
module demux1_4_seq
    import demux_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NCH*W-1:0] out_data,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [SEL_W-1:0] cur_sel
);

    sel_t           s;
    logic           accept;
    logic [NCH-1:0] load;
    logic [NCH-1:0] pop;

`ifdef DEMUX_RR_EN
    sel_t rr_ptr;
    logic unused_sel;

    // Pointer steps only on accept; a stalled channel blocks without skipping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_ptr + sel_t'(1);
        end
    end

    assign s          = rr_ptr;
    assign unused_sel = ^in_sel;
`else
    assign s = in_sel;
`endif

    assign cur_sel  = s;
    assign in_ready = ~out_valid[s] | out_ready[s];
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    always_comb begin
        load    = '0;
        load[s] = accept;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .W(W)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .d     (in_data),
            .pop   (pop[k]),
            .q     (out_data[k*W +: W]),
            .valid (out_valid[k])
        );
    end

endmodule

// File: tb/tb_demux1_4_seq.sv
// Self-checking bench for demux1_4_seq: vector table plus per-channel scoreboard.
module tb_demux1_4_seq;

    localparam int unsigned W = 8;

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [7:0] d;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [1:0] exp_sel;
        logic [3:0] exp_ov;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [1:0]     cur_sel;

    int         checks;
    int         errors;
    logic [7:0] sb [4][$];
    logic [3:0] prev_ov;
    vec_t       tbl [$];

    demux1_4_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cur_sel   (cur_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [1:0] sel, input logic [7:0] d,
                                input logic [3:0] ordy, input logic exp_rdy,
                                input logic [1:0] exp_sel, input logic [3:0] exp_ov);
        vec_t v;
        v.iv = iv; v.sel = sel; v.d = d; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_sel = exp_sel; v.exp_ov = exp_ov;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        logic [7:0] want;
        @(negedge clk);
        in_valid  = v.iv;
        in_sel    = v.sel;
        in_data   = v.d;
        out_ready = v.ordy;
        #1;
        chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.exp_rdy));
        chk($sformatf("v%0d cur_sel", idx), 32'(cur_sel), 32'(v.exp_sel));
        // Pops retire the oldest expected word before any same-cycle push.
        for (int k = 0; k < 4; k++) begin
            if (prev_ov[k] && v.ordy[k]) begin
                chk($sformatf("v%0d sb_depth%0d", idx, k), 32'(sb[k].size()), 32'd1);
                if (sb[k].size() > 0) begin
                    want = sb[k].pop_front();
                    chk($sformatf("v%0d pop_data%0d", idx, k), 32'(out_data[k*8 +: 8]), 32'(want));
                end
            end
        end
        if (v.iv && v.exp_rdy) sb[v.exp_sel].push_back(v.d);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_ov));
        for (int k = 0; k < 4; k++) begin
            if (v.exp_ov[k] && sb[k].size() > 0)
                chk($sformatf("v%0d hold_data%0d", idx, k), 32'(out_data[k*8 +: 8]), 32'(sb[k][0]));
        end
        prev_ov = v.exp_ov;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        prev_ov = 4'b0000;
        rst_n   = 1'b0;

        // Reset with random inputs on the bus.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_sel    = 2'($urandom);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            #1;
            chk("rst out_valid", 32'(out_valid), 32'd0);
            chk("rst out_data", out_data, 32'd0);
            chk("rst in_ready", 32'(in_ready), 32'd1);
`ifdef DEMUX_RR_EN
            chk("rst cur_sel", 32'(cur_sel), 32'd0);
`else
            chk("rst cur_sel", 32'(cur_sel), 32'(in_sel));
`endif
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

`ifdef DEMUX_RR_EN
        tbl.push_back(mk(1'b1, 2'd3, 8'h01, 4'b0000, 1'b1, 2'd0, 4'b0001));
        tbl.push_back(mk(1'b1, 2'd3, 8'h02, 4'b0000, 1'b1, 2'd1, 4'b0011));
        tbl.push_back(mk(1'b1, 2'd3, 8'h03, 4'b0000, 1'b1, 2'd2, 4'b0111));
        tbl.push_back(mk(1'b1, 2'd3, 8'h04, 4'b0000, 1'b1, 2'd3, 4'b1111));
        tbl.push_back(mk(1'b1, 2'd3, 8'h05, 4'b0001, 1'b1, 2'd0, 4'b1111));
        tbl.push_back(mk(1'b1, 2'd3, 8'h06, 4'b0000, 1'b0, 2'd1, 4'b1111));
        tbl.push_back(mk(1'b1, 2'd3, 8'h06, 4'b0010, 1'b1, 2'd1, 4'b1111));
`else
        tbl.push_back(mk(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 2'd2, 4'b0100));
        tbl.push_back(mk(1'b1, 2'd1, 8'h11, 4'b0000, 1'b1, 2'd1, 4'b0110));
        tbl.push_back(mk(1'b1, 2'd1, 8'h22, 4'b0000, 1'b0, 2'd1, 4'b0110));
        tbl.push_back(mk(1'b1, 2'd1, 8'h22, 4'b0010, 1'b1, 2'd1, 4'b0110));
        tbl.push_back(mk(1'b1, 2'd0, 8'h66, 4'b0000, 1'b1, 2'd0, 4'b0111));
        tbl.push_back(mk(1'b1, 2'd3, 8'h33, 4'b0000, 1'b1, 2'd3, 4'b1111));
        tbl.push_back(mk(1'b1, 2'd0, 8'h77, 4'b0000, 1'b0, 2'd0, 4'b1111));
        tbl.push_back(mk(1'b1, 2'd2, 8'h44, 4'b0100, 1'b1, 2'd2, 4'b1111));
        tbl.push_back(mk(1'b1, 2'd2, 8'h55, 4'b0100, 1'b1, 2'd2, 4'b1111));
        tbl.push_back(mk(1'b1, 2'd1, 8'h88, 4'b1001, 1'b0, 2'd1, 4'b0110));
        tbl.push_back(mk(1'b0, 2'd3, 8'h00, 4'b0110, 1'b1, 2'd3, 4'b0000));
        tbl.push_back(mk(1'b1, 2'd3, 8'h99, 4'b1111, 1'b1, 2'd3, 4'b1000));
        tbl.push_back(mk(1'b1, 2'd0, 8'hAA, 4'b1000, 1'b1, 2'd0, 4'b0001));
        tbl.push_back(mk(1'b1, 2'd0, 8'hBB, 4'b0001, 1'b1, 2'd0, 4'b0001));
        tbl.push_back(mk(1'b1, 2'd1, 8'hC1, 4'b0000, 1'b1, 2'd1, 4'b0011));
        tbl.push_back(mk(1'b1, 2'd2, 8'hC2, 4'b0000, 1'b1, 2'd2, 4'b0111));
`endif
        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

        // Asynchronous reset between edges with several channels full.
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async out_data", out_data, 32'd0);
        for (int k = 0; k < 4; k++) sb[k].delete();
        prev_ov = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // Traffic resumes from a clean state (pointer back at 0 in round-robin mode).
        apply_vec(mk(1'b1, 2'd0, 8'hD0, 4'b0000, 1'b1, 2'd0, 4'b0001), 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
